shreg_seq: RTL and testbench
============================

Name: shreg_seq

Overview:
Parametrised universal shift register with a command handshake. A single start pulse loads or shifts the register by a programmable number of steps, one bit per clock. It extends the existing fixed 5-bit right shifter with OR-feedback: width is generic, direction and mode are selectable, multi-step runs take a count, and busy/done status is provided. It sits between serial-data test stimulus and the display/compare logic in the lab designs.

Parameters:
WIDTH, 5, register width in bits (≥2).
AMT_W, 3, width of the step-count input; max run = 2^AMT_W-1 steps.

Ports:
clk  input  1  clock, rising-edge active.
reset  input  1  asynchronous, active-low; 0 clears all state immediately.
start  input  1  command strobe; sampled only while busy=0.
mode  input  2  00 LOAD, 01 SHR, 10 SHL, 11 ROR_OR.
amount  input  AMT_W  number of shift steps; ignored for LOAD.
din  input  WIDTH  parallel load data.
sin  input  1  serial input; sampled live on every shift step.
s  output  WIDTH  register contents.
sout  output  1  registered copy of the last bit shifted out.
busy  output  1  high while a shift run is in progress.
done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (reset=0, asynchronous): s=0, sout=0, busy=0, done=0, FSM=IDLE. Applies even mid-run; the run is discarded without a done pulse.
- FSM states: IDLE, SHIFT. The remaining-step counter has AMT_W bits. Mode is latched at start.
- IDLE, start=1, mode=LOAD: at the next edge s<=din, sout<=0, done=1 for that cycle, busy stays 0.
- IDLE, start=1, shift mode, amount=0: at the next edge done=1; s and sout are unchanged; busy stays 0.
- IDLE, start=1, shift mode, amount=N>0: latch mode and N, then go to SHIFT with busy=1. Each following edge performs one step and decrements the counter. The edge that performs step N sets busy=0 and done=1 (one cycle) and returns to IDLE.
- Timing: start sampled at edge k → steps at edges k+1..k+N → busy high after edge k through edge k+N, done high for the cycle after edge k+N.
- Step definitions:
  - SHR: s <= {sin, s[WIDTH-1:1]}, sout <= s[0].
  - SHL: s <= {s[WIDTH-2:0], sin}, sout <= s[WIDTH-1].
  - ROR_OR: s <= {s[0]|sin, s[WIDTH-1:1]}, sout <= s[0]. This is the legacy OR-feedback behaviour.
- start while busy=1 is ignored; it is neither queued nor an error.
- Changes to mode, amount or din during SHIFT have no effect. sin is used on every step.
- N greater than WIDTH is legal; shifting simply continues past WIDTH.
- done and a new start may coincide: start is accepted in that cycle because busy=0.

Optional Feature:
Macro SHREG_ABORT_EN.
- With the macro: extra input abort (1 bit) and output aborted (1 bit, reset 0). abort=1 in SHIFT means the next edge performs no step, returns to IDLE, clears busy, and pulses aborted for one cycle with done=0. s and sout keep their partially shifted values. abort in IDLE has no effect. If abort coincides with the final step edge, abort wins: no final step and no done.
- Without the macro: neither port exists and runs always complete.

Decomposition:
- Package shreg_pkg holds:
  - mode constants MODE_LOAD, MODE_SHR, MODE_SHL, MODE_ROR_OR;
  - state encoding ST_IDLE, ST_SHIFT.
- One sub-module, shreg_step: combinational next-{s, sout} from (s, sin, mode), parametrised by WIDTH. shreg_seq holds the FSM, counter and registers.

Test Plan:
- Reset low mid-run (SHR, N=5, at step 2) → s=00000, busy=0, done never pulses; after release, start LOAD din=10110 → s=10110, done one cycle, busy=0.
- s=10110, SHR, N=2, sin=1 → s=11011 then 11101; busy high 2 cycles; done on the cycle after step 2; sout=1.
- s=10110, SHL, N=3, sin=0 → 01100, 11000, 10000; sout=1.
- s=00001, ROR_OR, N=5, sin=0 → bit walks 10000…00001, final s=00001. Repeat with sin=1 for N=2 → 10000, 11000.
- amount=0 SHR → done next cycle, s unchanged; start asserted while busy → ignored, run length unchanged.
- (SHREG_ABORT_EN) s=11111, SHR, N=4, sin=0, abort at the cycle after step 1 → s=01111, aborted pulse, done=0, busy=0.

Source files
------------

// File: rtl/shreg_pkg.sv
// Shared definitions for the shreg_seq universal shift register:
// command mode encodings and FSM state encoding.
package shreg_pkg;

  localparam logic [1:0] MODE_LOAD   = 2'b00;
  localparam logic [1:0] MODE_SHR    = 2'b01;
  localparam logic [1:0] MODE_SHL    = 2'b10;
  localparam logic [1:0] MODE_ROR_OR = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/shreg_step.sv
// One shift step: next register contents and shifted-out bit for the
// given mode. Purely combinational.
module shreg_step
  import shreg_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] s,
  input  logic             sin,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] s_next,
  output logic             sout_next
);

  // Step datapath selected by the latched mode
  always_comb begin
    s_next    = s;
    sout_next = 1'b0;
    case (mode)
      MODE_SHR: begin
        s_next    = {sin, s[WIDTH-1:1]};
        sout_next = s[0];
      end
      MODE_SHL: begin
        s_next    = {s[WIDTH-2:0], sin};
        sout_next = s[WIDTH-1];
      end
      // Legacy OR-feedback rotate: the wrapped LSB is ORed with sin
      MODE_ROR_OR: begin
        s_next    = {s[0] | sin, s[WIDTH-1:1]};
        sout_next = s[0];
      end
      default: begin
        s_next    = s;
        sout_next = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shreg_seq.sv
// Universal shift register with start/busy/done handshake and multi-step runs.
// Define SHREG_ABORT_EN to add the abort input and aborted status pulse.
module shreg_seq
  import shreg_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
`ifdef SHREG_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic [WIDTH-1:0] s,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  state_t           state_r, state_s;
  logic [AMT_W-1:0] cnt_r, cnt_s;
  logic [1:0]       mode_r, mode_s;
  logic [WIDTH-1:0] s_r, s_s, step_s_s;
  logic             sout_r, sout_s, step_sout_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             abort_s;
  logic             aborted_r, aborted_s;

`ifdef SHREG_ABORT_EN
  assign abort_s = abort;
  assign aborted = aborted_r;
`else
  assign abort_s = 1'b0;
`endif

  shreg_step #(.WIDTH(WIDTH)) u_step (
    .s         (s_r),
    .sin       (sin),
    .mode      (mode_r),
    .s_next    (step_s_s),
    .sout_next (step_sout_s)
  );

  // Next-state, counter and output-register logic
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    mode_s    = mode_r;
    s_s       = s_r;
    sout_s    = sout_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    aborted_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (mode == MODE_LOAD) begin
            s_s    = din;
            sout_s = 1'b0;
            done_s = 1'b1;
          end else if (amount == {AMT_W{1'b0}}) begin
            done_s = 1'b1;
          end else begin
            mode_s  = mode;
            cnt_s   = amount;
            state_s = ST_SHIFT;
            busy_s  = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // Abort takes priority over the step, including the final one
        if (abort_s) begin
          state_s   = ST_IDLE;
          busy_s    = 1'b0;
          aborted_s = 1'b1;
        end else begin
          s_s    = step_s_s;
          sout_s = step_sout_s;
          cnt_s  = cnt_r - {{(AMT_W-1){1'b0}}, 1'b1};
          if (cnt_r == {{(AMT_W-1){1'b0}}, 1'b1}) begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            state_s = ST_SHIFT;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {AMT_W{1'b0}};
      mode_r    <= MODE_LOAD;
      s_r       <= {WIDTH{1'b0}};
      sout_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      mode_r    <= mode_s;
      s_r       <= s_s;
      sout_r    <= sout_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      aborted_r <= aborted_s;
    end
  end

  assign s    = s_r;
  assign sout = sout_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_shreg_seq.sv
// Directed self-checking bench for shreg_seq (WIDTH=5, AMT_W=3).
// Covers the abort path when SHREG_ABORT_EN is defined.
module tb_shreg_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] mode;
  logic [2:0] amount;
  logic [4:0] din;
  logic       sin;
  logic [4:0] s;
  logic       sout;
  logic       busy;
  logic       done;
`ifdef SHREG_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  int vectors    = 0;
  int miscompares = 0;

  shreg_seq #(.WIDTH(5), .AMT_W(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mode   (mode),
    .amount (amount),
    .din    (din),
    .sin    (sin),
`ifdef SHREG_ABORT_EN
    .abort  (abort),
    .aborted(aborted),
`endif
    .s      (s),
    .sout   (sout),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [4:0] es, input logic eo,
                           input logic eb, input logic ed);
    check({tag, ".s"},    32'(s),    32'(es));
    check({tag, ".sout"}, 32'(sout), 32'(eo));
    check({tag, ".busy"}, 32'(busy), 32'(eb));
    check({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  task automatic load(input logic [4:0] d);
    start = 1'b1; mode = 2'b00; din = d;
    tick();
    start = 1'b0;
    chk_state("load", d, 1'b0, 1'b0, 1'b1);
  endtask

  logic [4:0] ror_exp [5];

  initial begin
    reset = 1'b0; start = 1'b0; mode = 2'b00; amount = 3'd0; din = 5'b00000; sin = 1'b0;
`ifdef SHREG_ABORT_EN
    abort = 1'b0;
`endif
    ror_exp[0] = 5'b10000; ror_exp[1] = 5'b01000; ror_exp[2] = 5'b00100;
    ror_exp[3] = 5'b00010; ror_exp[4] = 5'b00001;
    #1;
    chk_state("reset", 5'b00000, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    tick();

    // Reset mid-run: SHR N=5 from 11111, reset after step 2
    load(5'b11111);
    start = 1'b1; mode = 2'b01; amount = 3'd5; sin = 1'b0;
    tick();
    start = 1'b0;
    chk_state("rst_run.start", 5'b11111, 1'b0, 1'b1, 1'b0);
    tick();
    chk_state("rst_run.step1", 5'b01111, 1'b1, 1'b1, 1'b0);
    tick();
    chk_state("rst_run.step2", 5'b00111, 1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    chk_state("rst_run.async", 5'b00000, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_run.no_done", 32'(done), 32'(1'b0));
    reset = 1'b1;
    tick();
    check("rst_run.idle_busy", 32'(busy), 32'(1'b0));

    // LOAD then SHR N=2 sin=1
    load(5'b10110);
    tick();
    check("load.done_clear", 32'(done), 32'(1'b0));
    start = 1'b1; mode = 2'b01; amount = 3'd2; sin = 1'b1;
    tick();
    start = 1'b0;
    chk_state("shr.start", 5'b10110, 1'b0, 1'b1, 1'b0);
    tick();
    chk_state("shr.step1", 5'b11011, 1'b0, 1'b1, 1'b0);
    tick();
    chk_state("shr.step2", 5'b11101, 1'b1, 1'b0, 1'b1);
    tick();
    check("shr.done_pulse", 32'(done), 32'(1'b0));

    // SHL N=3 sin=0 from 10110
    load(5'b10110);
    start = 1'b1; mode = 2'b10; amount = 3'd3; sin = 1'b0;
    tick();
    start = 1'b0;
    tick();
    chk_state("shl.step1", 5'b01100, 1'b1, 1'b1, 1'b0);
    tick();
    chk_state("shl.step2", 5'b11000, 1'b0, 1'b1, 1'b0);
    tick();
    chk_state("shl.step3", 5'b10000, 1'b1, 1'b0, 1'b1);

    // ROR_OR N=5 sin=0 from 00001: the set bit walks all the way round
    load(5'b00001);
    start = 1'b1; mode = 2'b11; amount = 3'd5; sin = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("ror0.step%0d.s", i + 1), 32'(s), 32'(ror_exp[i]));
      check($sformatf("ror0.step%0d.done", i + 1), 32'(done), 32'(i == 4));
    end
    check("ror0.sout", 32'(sout), 32'(1'b0));

    // ROR_OR N=2 sin=1 from 00001
    start = 1'b1; mode = 2'b11; amount = 3'd2; sin = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk_state("ror1.step1", 5'b10000, 1'b1, 1'b1, 1'b0);
    tick();
    chk_state("ror1.step2", 5'b11000, 1'b0, 1'b0, 1'b1);

    // amount=0: immediate done, register untouched
    start = 1'b1; mode = 2'b01; amount = 3'd0; sin = 1'b1;
    tick();
    start = 1'b0;
    chk_state("amt0", 5'b11000, 1'b0, 1'b0, 1'b1);

    // start held and inputs churned during a run: no effect on length or data
    start = 1'b1; mode = 2'b01; amount = 3'd3; sin = 1'b0;
    tick();
    mode = 2'b00; amount = 3'd7; din = 5'b11111;
    tick();
    chk_state("busy_start.step1", 5'b01100, 1'b0, 1'b1, 1'b0);
    tick();
    chk_state("busy_start.step2", 5'b00110, 1'b0, 1'b1, 1'b0);
    tick();
    start = 1'b0;
    chk_state("busy_start.step3", 5'b00011, 1'b0, 1'b0, 1'b1);
    tick();
    chk_state("busy_start.after", 5'b00011, 1'b0, 1'b0, 1'b0);

`ifdef SHREG_ABORT_EN
    // Abort after step 1 of SHR N=4
    load(5'b11111);
    start = 1'b1; mode = 2'b01; amount = 3'd4; sin = 1'b0;
    tick();
    start = 1'b0;
    tick();
    chk_state("abort.step1", 5'b01111, 1'b1, 1'b1, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_state("abort.edge", 5'b01111, 1'b1, 1'b0, 1'b0);
    check("abort.aborted", 32'(aborted), 32'(1'b1));
    tick();
    chk_state("abort.after", 5'b01111, 1'b1, 1'b0, 1'b0);
    check("abort.pulse_end", 32'(aborted), 32'(1'b0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
